// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit -- iterative radix-2 multiply/divide unit feeding the HI/LO regs.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   start        launch an operation (accepted only while idle)
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b         operands, sampled with start
//   cancel       synchronous abort of the in-flight operation
//   busy         operation in flight
//   done         one-cycle pulse: hi/lo/div_by_zero just updated
//   hi, lo       product high/low, or remainder/quotient
//   div_by_zero  last completed divide had b == 0
//
// Optional feature: define MULDIV_EARLY_OUT_EN to let multiplies finish as
// soon as the remaining multiplier bits are all zero.
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;

  state_e             state_q, state_d;
  logic               is_div_q, is_div_d;
  logic               zdiv_q, zdiv_d;      // divide with b == 0 pending
  logic               neg_lo_q, neg_lo_d;  // negate product / quotient
  logic               neg_hi_q, neg_hi_d;  // negate remainder
  logic [2*WIDTH-1:0] acc_q, acc_d;        // product accumulator / remainder
  logic [2*WIDTH-1:0] opd_q, opd_d;        // shifted multiplicand / divisor
  logic [WIDTH-1:0]   sh_q, sh_d;          // multiplier / dividend->quotient
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               dbz_q, dbz_d;
  logic               done_q, done_d;

  // Operand magnitudes; only the signed ops (op[0]==0) look at sign bits.
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  // Datapath temporaries
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH+1:0]   diff;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    a_neg = ~op[0] & a[WIDTH-1];
    b_neg = ~op[0] & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d   = state_q;
    is_div_d  = is_div_q;
    zdiv_d    = zdiv_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    acc_d     = acc_q;
    opd_d     = opd_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;
    rem_shift = {acc_q[WIDTH-1:0], sh_q[WIDTH-1]};
    diff      = {1'b0, rem_shift} - {2'b00, opd_q[WIDTH-1:0]};
    prod      = neg_lo_q ? -acc_q : acc_q;

    unique case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          is_div_d = op[1];
          zdiv_d   = op[1] && (b == '0);
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = op[1] ? a_neg : (a_neg ^ b_neg);
          acc_d    = '0;
          cnt_d    = '0;
          if (op[1]) begin
            opd_d = {{WIDTH{1'b0}}, b_mag};
            // A zero divisor reports the raw dividend, so keep it unmodified.
            sh_d  = (b == '0) ? a : a_mag;
          end else begin
            opd_d = {{WIDTH{1'b0}}, a_mag};
            sh_d  = b_mag;
          end
          state_d = RUN;
        end
      end

      RUN: begin
        if (cancel) begin
          state_d = IDLE;
        end else if (zdiv_q) begin
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (!is_div_q) begin
            // Shift-add: multiplicand moves left, multiplier drains right.
            if (sh_q[0]) acc_d = acc_q + opd_q;
            opd_d = opd_q << 1;
            sh_d  = sh_q >> 1;
          end else if (!diff[WIDTH+1]) begin
            // Trial subtract succeeded: keep difference, shift in a 1.
            acc_d = {{(WIDTH-1){1'b0}}, diff[WIDTH:0]};
            sh_d  = {sh_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {{(WIDTH-1){1'b0}}, rem_shift};
            sh_d  = {sh_q[WIDTH-2:0], 1'b0};
          end
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = FINISH;
          end
`ifdef MULDIV_EARLY_OUT_EN
          else if (!is_div_q && ((sh_q >> 1) == '0)) begin
            state_d = FINISH;
          end
`else
`endif
        end
      end

      FINISH: begin
        state_d = IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          dbz_d  = zdiv_q;
          if (zdiv_q) begin
            hi_d = sh_q;
            lo_d = '1;
          end else if (is_div_q) begin
            hi_d = neg_hi_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            lo_d = neg_lo_q ? -sh_q : sh_q;
          end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, so hi/lo read zero after reset
  // rather than whatever the operand registers powered up with.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      is_div_q <= 1'b0;
      zdiv_q   <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      acc_q    <= '0;
      opd_q    <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      is_div_q <= is_div_d;
      zdiv_q   <= zdiv_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      acc_q    <= acc_d;
      opd_q    <= opd_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
      done_q   <= done_d;
    end
  end

  // done is registered out of FINISH, so it is high while the FSM is idle.
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01,
                         OP_DIV  = 2'b10, OP_DIVU  = 2'b11;

  logic        clk, reset, start, cancel;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_hi, last_lo;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic; latency counted in edges after start.
  function automatic void model(input logic [1:0] o, input logic [31:0] x, y,
                                output logic [31:0] eh, el,
                                output logic ez, output int lat);
    longint          sx, sy, sp;
    longint unsigned up;
    logic [31:0]     mag;
    int              bits;
    ez  = 1'b0;
    lat = 33;
    eh  = '0;
    el  = '0;
    case (o)
      OP_MULT: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        {eh, el} = sp;
      end
      OP_MULTU: begin
        up = {32'b0, x} * {32'b0, y};
        {eh, el} = up;
      end
      default: begin
        if (y == 0) begin
          el = '1; eh = x; ez = 1'b1; lat = 2;
        end else if (o == OP_DIV) begin
          sx = longint'($signed(x));
          sy = longint'($signed(y));
          el = 32'(sx / sy);
          eh = 32'(sx % sy);
        end else begin
          el = x / y;
          eh = x % y;
        end
      end
    endcase
`ifdef MULDIV_EARLY_OUT_EN
    if (!o[1]) begin
      mag  = (o == OP_MULT && y[31]) ? -y : y;
      bits = 1;
      for (int i = 0; i < 32; i++) if (mag[i]) bits = i + 1;
      lat = bits + 1;
    end
`else
    mag  = '0;
    bits = 0;
`endif
  endfunction

  // Runs one operation. inject_at > 0 pulses a competing start at that many
  // edges after the accepted start; it must be ignored.
  task automatic do_op(input string name, input logic [1:0] o,
                       input logic [31:0] x, y, input int inject_at);
    logic [31:0] eh, el;
    logic        ez;
    int          lat, n;
    bit          seen;
    model(o, x, y, eh, el, ez, lat);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;                       // accepted at this edge
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
    n = 0; seen = 0;
    while (n < 100 && !seen) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (done) seen = 1;
      else if (inject_at > 0 && n == inject_at) begin
        start = 1'b1; op = OP_MULTU; a = 32'd11; b = 32'd13;
      end else start = 1'b0;
    end
    start = 1'b0;
    checks++;
    if (!seen || n != lat) begin
      errors++;
      $display("FAIL %s latency: got %0d edges (seen=%0d), want %0d", name, n, seen, lat);
    end
    checks++;
    if (hi !== eh || lo !== el) begin
      errors++;
      $display("FAIL %s result: got hi=%h lo=%h, want hi=%h lo=%h", name, hi, lo, eh, el);
    end
    checks++;
    if (div_by_zero !== ez) begin
      errors++;
      $display("FAIL %s div_by_zero: got %b, want %b", name, div_by_zero, ez);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy with done: got %b, want 0", name, busy);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after done: got done=%b busy=%b, want 0 0", name, done, busy);
    end
    last_hi = eh;
    last_lo = el;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || hi !== 0 || lo !== 0) begin
      errors++;
      $display("FAIL reset state: got busy=%b done=%b dbz=%b hi=%h lo=%h, want all 0",
               busy, done, div_by_zero, hi, lo);
    end
    #1 reset = 1'b1;
    last_hi = '0; last_lo = '0;
  endtask

  task automatic test_directed();
    do_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'd7, 0);
    do_op("mult_by1",  OP_MULT,  32'd5, 32'd1, 0);
    do_op("mult_zero", OP_MULT,  32'h8000_0000, 32'd0, 0);
    do_op("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'd2, 0);
    do_op("divu_100",  OP_DIVU,  32'd100, 32'd7, 0);
    do_op("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("div_negb",  OP_DIV,   32'd7, 32'hFFFF_FFFE, 0);
  endtask

  task automatic test_div_by_zero();
    do_op("divu_z",    OP_DIVU,  32'h1234, 32'd0, 0);
    do_op("after_z",   OP_MULTU, 32'd2, 32'd3, 0);
    do_op("div_negz",  OP_DIV,   32'hFFFF_FF00, 32'd0, 0);
  endtask

  task automatic test_cancel();
    bit seen;
    @(posedge clk); #1;
    start = 1'b1; op = OP_MULTU; a = 32'd2; b = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk); #1 cancel = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    checks++;
    if (seen || busy !== 1'b0) begin
      errors++;
      $display("FAIL cancel: got done_seen=%0d busy=%b, want 0 0", seen, busy);
    end
    checks++;
    if (hi !== last_hi || lo !== last_lo) begin
      errors++;
      $display("FAIL cancel retention: got hi=%h lo=%h, want hi=%h lo=%h",
               hi, lo, last_hi, last_lo);
    end
    // start together with cancel while idle is dropped
    @(posedge clk); #1;
    start = 1'b1; cancel = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL cancel_idle: got busy=%b, want 0", busy);
    end
  endtask

  task automatic test_start_ignored();
    do_op("inject_run", OP_DIVU,  32'd100, 32'd7, 5);
    do_op("inject_fin", OP_MULT,  32'hFFFF_FFFD, 32'd7, 32);
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      x = $urandom;
      case ($urandom_range(0, 7))
        0:       y = 32'd0;
        1, 2:    y = 32'($urandom_range(1, 300));
        3:       y = 32'hFFFF_FFFF;
        default: y = $urandom;
      endcase
      do_op("random", o, x, y, 0);
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || hi !== 0 || lo !== 0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b done=%b dbz=%b hi=%h lo=%h, want all 0",
               busy, done, div_by_zero, hi, lo);
    end
    @(posedge clk); #1 reset = 1'b1;
    last_hi = '0; last_lo = '0;
    do_op("after_rst", OP_DIVU, 32'd9, 32'd3, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_by_zero();
    do_op("prime", OP_MULTU, 32'd123, 32'd456, 0);
    test_cancel();
    test_start_ignored();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
